wishbone_bus_if: RTL and testbench

//  Wishbone B3 classic master bridge between the CPU core's flat memory ports and the SoC bus.
//  Two instances sit outside the core: one on the instruction port (rom_*), one on the data port (ram_*).
//  - Turns each single-cycle CPU request into one Wishbone cycle.
//  - Raises stallreq to the pipeline controller until the bus acks or times out.
//  - Holds read data while the pipeline stays stalled for other reasons.

---
 rtl/wishbone_bus_if.sv | 141 ++++++++++++++
 tb/tb_wishbone_bus_if.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_bus_if.sv
// Wishbone B3 classic single-transfer master bridging a flat CPU memory port to the SoC bus.
// One bus cycle per CPU request, with stall request, flush abort, timeout and read-data hold.
module wishbone_bus_if #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq,
    output logic        bus_err_o,
    output logic [31:0] wishbone_addr_o,
    output logic [31:0] wishbone_data_o,
    input  logic [31:0] wishbone_data_i,
    output logic        wishbone_we_o,
    output logic [3:0]  wishbone_sel_o,
    output logic        wishbone_stb_o,
    output logic        wishbone_cyc_o,
    input  logic        wishbone_ack_i,
    output logic [1:0]  o_dbg_state
);

    // Handshake: a request is accepted when cpu_ce_i && !flush_i in IDLE; the CPU keeps it
    // stable while stallreq is high. The bus side holds CYC/STB until ACK_I, flush or timeout.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [31:0] r_rd_buf;
    logic        w_issue;
    logic        w_timeout;

    assign w_issue     = (r_state == ST_IDLE) && cpu_ce_i && !flush_i;
    assign w_timeout   = (TIMEOUT_CYC != 0) && (r_cnt == TO_LAST);
    assign o_dbg_state = r_state;

    always_comb begin
        w_next     = r_state;
        stallreq   = 1'b0;
        cpu_data_o = 32'h0;
        case (r_state)
            ST_IDLE: begin
                stallreq = cpu_ce_i && !flush_i;
                if (w_issue) begin
                    w_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (flush_i) begin
                    w_next = ST_IDLE;
                end else if (wishbone_ack_i) begin
                    w_next = (stall_i != 6'd0) ? ST_WAIT : ST_IDLE;
                    if (!wishbone_we_o) begin
                        cpu_data_o = wishbone_data_i;
                    end
                end else if (w_timeout) begin
                    w_next = ST_IDLE;
                end else begin
                    stallreq = 1'b1;
                end
            end
            ST_WAIT: begin
                cpu_data_o = r_rd_buf;
                if (stall_i == 6'd0) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
        // Reset is asynchronous, so the stall request must fall with it rather than at the next edge.
        if (rst) begin
            stallreq = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_cnt           <= 8'h0;
            r_rd_buf        <= 32'h0;
            bus_err_o       <= 1'b0;
            wishbone_addr_o <= 32'h0;
            wishbone_data_o <= 32'h0;
            wishbone_we_o   <= 1'b0;
            wishbone_sel_o  <= 4'h0;
            wishbone_stb_o  <= 1'b0;
            wishbone_cyc_o  <= 1'b0;
        end else begin
            r_state   <= w_next;
            bus_err_o <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        wishbone_addr_o <= cpu_addr_i & 32'hFFFF_FFFC;
                        wishbone_data_o <= cpu_data_i;
                        wishbone_we_o   <= cpu_we_i;
                        wishbone_sel_o  <= cpu_sel_i;
                        wishbone_stb_o  <= 1'b1;
                        wishbone_cyc_o  <= 1'b1;
                        r_cnt           <= 8'h0;
                    end
                end
                ST_BUSY: begin
                    if (flush_i || wishbone_ack_i || w_timeout) begin
                        wishbone_stb_o  <= 1'b0;
                        wishbone_cyc_o  <= 1'b0;
                        wishbone_addr_o <= 32'h0;
                        wishbone_sel_o  <= 4'h0;
                        r_cnt           <= 8'h0;
                        if (flush_i) begin
                            r_rd_buf <= 32'h0;
                        end else if (wishbone_ack_i) begin
                            if (!wishbone_we_o) begin
                                r_rd_buf <= wishbone_data_i;
                            end
                        end else begin
                            bus_err_o <= 1'b1;
                        end
                    end else if (r_cnt != 8'hFF) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wishbone_bus_if.sv
// Bench for wishbone_bus_if: table-driven transfers with an expected-data queue, plus
// hand-written flush, timeout and asynchronous-reset sequences.
module tb_wishbone_bus_if;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_i;
    logic        cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_o;
    logic        stallreq;
    logic        bus_err_o;
    logic [31:0] wishbone_addr_o;
    logic [31:0] wishbone_data_o;
    logic [31:0] wishbone_data_i;
    logic        wishbone_we_o;
    logic [3:0]  wishbone_sel_o;
    logic        wishbone_stb_o;
    logic        wishbone_cyc_o;
    logic        wishbone_ack_i;
    logic [1:0]  o_dbg_state;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          waits;
        logic [31:0] rdata;
        logic [5:0]  stall;
        int          hold;
        logic [31:0] exp_adr;
        logic [31:0] exp_cpu;
        logic [31:0] exp_wait;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    wishbone_bus_if #(.TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .cpu_ce_i(cpu_ce_i), .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i), .cpu_data_o(cpu_data_o),
        .stallreq(stallreq), .bus_err_o(bus_err_o),
        .wishbone_addr_o(wishbone_addr_o), .wishbone_data_o(wishbone_data_o),
        .wishbone_data_i(wishbone_data_i), .wishbone_we_o(wishbone_we_o),
        .wishbone_sel_o(wishbone_sel_o), .wishbone_stb_o(wishbone_stb_o),
        .wishbone_cyc_o(wishbone_cyc_o), .wishbone_ack_i(wishbone_ack_i),
        .o_dbg_state(o_dbg_state)
    );

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cpu_ce_i       = 1'b0;
        flush_i        = 1'b0;
        wishbone_ack_i = 1'b0;
        stall_i        = 6'd0;
    endtask

    // One CPU request: issue, v.waits unacked STB cycles, ack, optional stall hold, idle check.
    task automatic run_txn(input vec_t v);
        logic [95:0] bus_exp;
        logic [31:0] exp;
        bus_exp = {1'b1, 1'b1, v.we, v.sel, v.exp_adr, v.wdata};
        @(negedge clk);
        idle_inputs();
        cpu_ce_i   = 1'b1;
        cpu_addr_i = v.addr;
        cpu_data_i = v.wdata;
        cpu_we_i   = v.we;
        cpu_sel_i  = v.sel;
        exp_q.push_back(v.exp_cpu);
        #1;
        chk("req_stallreq", stallreq, 1);
        chk("req_cyc_low", {wishbone_cyc_o, wishbone_stb_o}, 0);
        for (int i = 0; i < v.waits; i++) begin
            @(negedge clk);
            wishbone_ack_i  = 1'b0;
            wishbone_data_i = $urandom;
            #1;
            chk("busy_bus", {wishbone_cyc_o, wishbone_stb_o, wishbone_we_o, wishbone_sel_o,
                             wishbone_addr_o, wishbone_data_o}, bus_exp);
            chk("busy_stallreq", stallreq, 1);
            chk("busy_cpu_data", cpu_data_o, 0);
        end
        @(negedge clk);
        cpu_ce_i        = 1'b0;
        wishbone_ack_i  = 1'b1;
        wishbone_data_i = v.rdata;
        stall_i         = v.stall;
        #1;
        chk("ack_bus", {wishbone_cyc_o, wishbone_stb_o, wishbone_we_o, wishbone_sel_o,
                        wishbone_addr_o, wishbone_data_o}, bus_exp);
        chk("ack_stallreq", stallreq, 0);
        exp = exp_q.pop_front();
        chk("ack_cpu_data", cpu_data_o, exp);
        if (v.stall != 6'd0) begin
            for (int i = 0; i < v.hold; i++) begin
                @(negedge clk);
                wishbone_ack_i = 1'b0;
                cpu_ce_i       = 1'b1;
                stall_i        = v.stall;
                #1;
                chk("wait_state", o_dbg_state, 2);
                chk("wait_data", cpu_data_o, v.exp_wait);
                chk("wait_no_issue", {wishbone_cyc_o, wishbone_stb_o, stallreq}, 0);
            end
            @(negedge clk);
            idle_inputs();
            #1;
            chk("wait_release_state", o_dbg_state, 2);
            chk("wait_release_data", cpu_data_o, v.exp_wait);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        chk("after_idle", {o_dbg_state, wishbone_cyc_o, wishbone_stb_o, wishbone_sel_o,
                           wishbone_addr_o, bus_err_o, stallreq, cpu_data_o}, 0);
    endtask

    initial begin
        vec_t v;
        logic [31:0] model_rd_buf;
        int stb_cnt;
        int err_cnt;

        // we, addr, wdata, sel, waits, rdata, stall, hold, exp_adr, exp_cpu, exp_wait
        vecs[0] = '{1'b0, 32'h0000_1000, 32'h0, 4'hF, 1, 32'hDEAD_BEEF, 6'd0, 0,
                    32'h0000_1000, 32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1'b1, 32'h0000_0104, 32'h1234_5678, 4'b0011, 3, 32'hFFFF_0000, 6'd0, 0,
                    32'h0000_0104, 32'h0, 32'h0};
        vecs[2] = '{1'b0, 32'h0000_2003, 32'hAAAA_5555, 4'b0001, 0, 32'hCAFE_F00D, 6'd0, 0,
                    32'h0000_2000, 32'hCAFE_F00D, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_0040, 32'h0, 4'hF, 1, 32'h5A5A_0001, 6'b000011, 3,
                    32'h0000_0040, 32'h5A5A_0001, 32'h5A5A_0001};
        vecs[4] = '{1'b1, 32'h7FFF_FFFE, 32'h0BAD_F00D, 4'b1100, 2, 32'h7777_7777, 6'b100000, 1,
                    32'h7FFF_FFFC, 32'h0, 32'h5A5A_0001};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF, 32'h0, 4'hF, 2, 32'h8000_0001, 6'd0, 0,
                    32'hFFFF_FFFC, 32'h8000_0001, 32'h0};

        rst = 1'b1;
        idle_inputs();
        cpu_addr_i      = 32'h0;
        cpu_data_i      = 32'h0;
        cpu_we_i        = 1'b0;
        cpu_sel_i       = 4'h0;
        wishbone_data_i = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {wishbone_cyc_o, wishbone_stb_o, wishbone_we_o, wishbone_sel_o,
                              wishbone_addr_o, wishbone_data_o, bus_err_o, stallreq, o_dbg_state}, 0);
        chk("reset_cpu_data", cpu_data_o, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i]);
        end

        model_rd_buf = 32'h8000_0001;
        for (int i = 0; i < 8; i++) begin
            v.we      = 1'($urandom_range(0, 1));
            v.addr    = $urandom;
            v.wdata   = $urandom;
            v.sel     = 4'($urandom_range(1, 15));
            v.waits   = $urandom_range(0, 3);
            v.rdata   = $urandom;
            v.stall   = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(1, 63)) : 6'd0;
            v.hold    = $urandom_range(0, 2);
            v.exp_adr = v.addr & 32'hFFFF_FFFC;
            v.exp_cpu = v.we ? 32'h0 : v.rdata;
            if (!v.we) model_rd_buf = v.rdata;
            v.exp_wait = model_rd_buf;
            run_txn(v);
        end

        // Flush in the ack cycle: flush wins and the held read buffer is cleared.
        v = '{1'b0, 32'h0000_0200, 32'h0, 4'hF, 0, 32'h9988_7766, 6'd0, 0,
              32'h0000_0200, 32'h9988_7766, 32'h0};
        run_txn(v);
        @(negedge clk);
        idle_inputs();
        cpu_ce_i   = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0000_0300;
        cpu_sel_i  = 4'hF;
        @(negedge clk);
        cpu_ce_i        = 1'b0;
        wishbone_ack_i  = 1'b1;
        wishbone_data_i = 32'h1111_2222;
        flush_i         = 1'b1;
        stall_i         = 6'b000001;
        #1;
        chk("flush_cpu_data", cpu_data_o, 0);
        chk("flush_stallreq", stallreq, 0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("flush_after", {o_dbg_state, wishbone_cyc_o, wishbone_stb_o}, 0);
        v = '{1'b1, 32'h0000_0310, 32'h4444_5555, 4'hF, 0, 32'h0, 6'b000100, 1,
              32'h0000_0310, 32'h0, 32'h0};
        run_txn(v);

        // Slave never acks: four STB cycles, then a single error pulse.
        @(negedge clk);
        idle_inputs();
        cpu_ce_i   = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0000_0500;
        stb_cnt    = 0;
        err_cnt    = 0;
        @(negedge clk);
        cpu_ce_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (wishbone_stb_o) stb_cnt++;
            if (bus_err_o) begin
                err_cnt++;
                chk("to_err_idle", {wishbone_cyc_o, wishbone_stb_o, stallreq}, 0);
            end
            @(negedge clk);
        end
        chk("to_stb_cycles", stb_cnt, 4);
        chk("to_err_pulses", err_cnt, 1);
        v = '{1'b0, 32'h0000_0504, 32'h0, 4'hF, 1, 32'h1357_2468, 6'd0, 0,
              32'h0000_0504, 32'h1357_2468, 32'h0};
        run_txn(v);

        // Asynchronous reset in the middle of a bus cycle.
        @(negedge clk);
        idle_inputs();
        cpu_ce_i   = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0000_0600;
        @(negedge clk);
        #1;
        chk("pre_rst_cyc", {wishbone_cyc_o, wishbone_stb_o, stallreq}, 3'b111);
        #2;
        rst      = 1'b1;
        cpu_ce_i = 1'b0;
        #1;
        chk("rst_async", {wishbone_cyc_o, wishbone_stb_o, stallreq, o_dbg_state}, 0);
        @(negedge clk);
        rst = 1'b0;
        run_txn(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
